// File: rtl/serial_paralelo_pkg.sv
// Shared definitions for the serial-to-parallel receiver (serial_paralelo) and
// its transmit-side counterpart (paralelo_serial).
// Holds the comma/idle symbol, the default qualification count, the receiver
// state encoding, the byte payload type and a saturating counter helper.
package serial_paralelo_pkg;

  localparam int unsigned WIDTH            = 8;
  localparam int unsigned BIT_CNT_W        = 3;
  localparam int unsigned COMMA_CNT_W      = 4;
  localparam int unsigned RX_CNT_W         = 16;
  localparam int unsigned DEF_SYNC_COUNT   = 4;
  localparam logic [WIDTH-1:0] DEF_COMMA   = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

  // Received byte as presented to the byte-rate logic.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } rx_byte_t;

  // Comma counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [COMMA_CNT_W-1:0] comma_cnt_inc(
    input logic [COMMA_CNT_W-1:0] cnt
  );
    if (cnt == {COMMA_CNT_W{1'b1}}) begin
      return cnt;
    end
    return cnt + COMMA_CNT_W'(1);
  endfunction

endpackage

// File: rtl/serial_paralelo_aligner.sv
// Bit-level front end of serial_paralelo: shift register, comma compare and
// the bit-within-byte counter that marks byte boundaries.
// Ports:
//   clk_32f      serial bit clock
//   reset_L      asynchronous active-low reset
//   data_in      serial data, MSB first
//   realign      restart byte framing so the current edge ends a byte
//   cand_c       8 bits ending with the bit sampled at this edge
//   boundary_c   this edge completes a byte in the current framing
//   comma_hit_c  cand_c equals the comma symbol
module serial_paralelo_aligner
  import serial_paralelo_pkg::*;
#(
  parameter logic [WIDTH-1:0] COMMA = DEF_COMMA
) (
  input  logic             clk_32f,
  input  logic             reset_L,
  input  logic             data_in,
  input  logic             realign,
  output logic [WIDTH-1:0] cand_c,
  output logic             boundary_c,
  output logic             comma_hit_c
);

  // Only the seven most recent bits need storing; the eighth is data_in itself.
  logic [WIDTH-2:0]     sr_q, sr_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  // Candidate byte, comma detect and boundary decode.
  always_comb begin
    cand_c      = {sr_q, data_in};
    comma_hit_c = (cand_c == COMMA);
    boundary_c  = (bit_cnt_q == BIT_CNT_W'(WIDTH - 1));
    sr_d        = cand_c[WIDTH-2:0];
    // Realigning sets the count to zero: the comma just seen closes a byte,
    // so the next boundary falls 8 edges later. Otherwise wrap 7 -> 0.
    if (realign) begin
      bit_cnt_d = '0;
    end else begin
      bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
    end
  end

  // Bit-rate state.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: recovers byte framing from a 1-bit stream by
// locking onto the comma symbol, qualifies the link after SYNC_COUNT aligned
// commas, then delivers data bytes with a valid flag (commas read as idle).
// Optional feature: define SERIAL_PARALELO_RXCNT_EN to add rx_count, a
// saturating count of data bytes accepted while ACTIVE.
// Ports:
//   clk_32f      serial bit clock, sole clock
//   reset_L      asynchronous active-low reset
//   data_in      serial data, MSB of each byte first
//   data_out     last received data byte, held between boundaries
//   valid_out    data_out holds a non-comma byte received while ACTIVE
//   byte_strobe  one-cycle pulse at every byte boundary in SYNC or ACTIVE
//   active       link aligned and qualified
//   rx_count     (SERIAL_PARALELO_RXCNT_EN only) accepted data byte count
module serial_paralelo
  import serial_paralelo_pkg::*;
#(
  parameter logic [WIDTH-1:0] COMMA      = DEF_COMMA,
  parameter int unsigned      SYNC_COUNT = DEF_SYNC_COUNT
) (
  input  logic                clk_32f,
  input  logic                reset_L,
  input  logic                data_in,
  output logic [WIDTH-1:0]    data_out,
  output logic                valid_out,
  output logic                byte_strobe,
  output logic                active
`ifdef SERIAL_PARALELO_RXCNT_EN
  ,
  output logic [RX_CNT_W-1:0] rx_count
`endif
);

  localparam logic [COMMA_CNT_W-1:0] SYNC_TGT = COMMA_CNT_W'(SYNC_COUNT);

  logic [WIDTH-1:0] cand_c;
  logic             boundary_c;
  logic             comma_hit_c;
  logic             realign_c;

  rx_state_e              state_q, state_d;
  logic [COMMA_CNT_W-1:0] comma_cnt_q, comma_cnt_d;
  rx_byte_t               out_q, out_d;
  logic                   byte_strobe_q, byte_strobe_d;
  logic                   active_q, active_d;
`ifdef SERIAL_PARALELO_RXCNT_EN
  logic [RX_CNT_W-1:0]    rx_count_q, rx_count_d;
`endif

  serial_paralelo_aligner #(
    .COMMA (COMMA)
  ) u_aligner (
    .clk_32f     (clk_32f),
    .reset_L     (reset_L),
    .data_in     (data_in),
    .realign     (realign_c),
    .cand_c      (cand_c),
    .boundary_c  (boundary_c),
    .comma_hit_c (comma_hit_c)
  );

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    comma_cnt_d   = comma_cnt_q;
    out_d         = out_q;
    byte_strobe_d = 1'b0;
    realign_c     = 1'b0;
`ifdef SERIAL_PARALELO_RXCNT_EN
    rx_count_d    = rx_count_q;
`endif

    unique case (state_q)
      // Any comma at any bit position establishes the framing.
      SEARCH: begin
        out_d.valid = 1'b0;
        if (comma_hit_c) begin
          realign_c   = 1'b1;
          comma_cnt_d = COMMA_CNT_W'(1);
          if (SYNC_TGT <= COMMA_CNT_W'(1)) begin
            state_d = ACTIVE;
          end else begin
            state_d = SYNC;
          end
        end
      end

      // Only aligned bytes are inspected; one non-comma drops the framing.
      SYNC: begin
        if (boundary_c) begin
          byte_strobe_d = 1'b1;
          if (comma_hit_c) begin
            comma_cnt_d = comma_cnt_inc(comma_cnt_q);
            if (comma_cnt_d >= SYNC_TGT) begin
              state_d = ACTIVE;
            end
          end else begin
            comma_cnt_d = '0;
            state_d     = SEARCH;
          end
        end
      end

      // Framing is trusted from here on: data may form a comma across a
      // boundary, so misaligned commas never cause a relock.
      ACTIVE: begin
        if (boundary_c) begin
          byte_strobe_d = 1'b1;
          if (comma_hit_c) begin
            out_d.valid = 1'b0;
          end else begin
            out_d.valid = 1'b1;
            out_d.data  = cand_c;
`ifdef SERIAL_PARALELO_RXCNT_EN
            if (rx_count_q != {RX_CNT_W{1'b1}}) begin
              rx_count_d = rx_count_q + RX_CNT_W'(1);
            end
`endif
          end
        end
      end

      default: begin
        state_d     = SEARCH;
        comma_cnt_d = '0;
        out_d.valid = 1'b0;
      end
    endcase

    active_d = (state_d == ACTIVE);
  end

  // Byte-level state and registered outputs.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q       <= SEARCH;
      comma_cnt_q   <= '0;
      out_q         <= '0;
      byte_strobe_q <= 1'b0;
      active_q      <= 1'b0;
`ifdef SERIAL_PARALELO_RXCNT_EN
      rx_count_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      comma_cnt_q   <= comma_cnt_d;
      out_q         <= out_d;
      byte_strobe_q <= byte_strobe_d;
      active_q      <= active_d;
`ifdef SERIAL_PARALELO_RXCNT_EN
      rx_count_q    <= rx_count_d;
`endif
    end
  end

  assign data_out    = out_q.data;
  assign valid_out   = out_q.valid;
  assign byte_strobe = byte_strobe_q;
  assign active      = active_q;
`ifdef SERIAL_PARALELO_RXCNT_EN
  assign rx_count    = rx_count_q;
`endif

endmodule

// File: doc/serial_paralelo.md
Name: serial_paralelo

Overview:
- Receive-side counterpart of paralelo_serial: converts the 1-bit serial stream back into 8-bit parallel bytes.
- Aligns byte boundaries by hunting for the comma/idle symbol COMMA and qualifies the link after SYNC_COUNT consecutive aligned commas.
- Once active, delivers received data bytes with a valid flag; commas are treated as idle.
- Sits at the far end of the serial link, feeding the byte-rate (clk_4f) logic.

Parameters:
- WIDTH, 8, symbol width in bits; fixed at 8 for this link.
- COMMA, 8'hBC, idle/alignment symbol sent by the transmitter when its valid is low.
- SYNC_COUNT, 4, consecutive aligned commas required to enter ACTIVE; range 1..15.

Ports:
- clk_32f  input  1  serial bit clock; one bit per rising edge. Sole clock of the block.
- reset_L  input  1  reset, asynchronous and active-low.
- data_in  input  1  serial data, MSB of each byte first.
- data_out  output  8  last received data byte; held between boundaries.
- valid_out  output  1  high while data_out holds a non-comma byte received in ACTIVE.
- byte_strobe  output  1  one-cycle pulse on every byte boundary while in SYNC or ACTIVE.
- active  output  1  link aligned and qualified (state ACTIVE).

Behaviour:
- reset_L low: clears all state immediately, without waiting for a clock edge.
  - Cleared: shift register, bit_cnt, comma_cnt, data_out=8'h00, valid_out=0, byte_strobe=0, active=0, state=SEARCH.
  - Reset mid-operation has the same effect and is legal at any time.
- Shift register: sr <= {sr[6:0], data_in} on every edge.
- Candidate byte: cand = {sr[6:0], data_in}, i.e. the 8 bits ending with the bit sampled at this edge.
- bit_cnt (3-bit) counts bits of the current byte already received.
  - A boundary is an edge where bit_cnt==7; bit_cnt then wraps to 0.
- State SEARCH:
  - Every edge: if cand==COMMA, then bit_cnt<=0, comma_cnt<=1, go to SYNC.
  - If SYNC_COUNT==1, go directly to ACTIVE instead.
  - Otherwise remain in SEARCH.
- State SYNC:
  - bit_cnt increments each edge.
  - At a boundary with cand==COMMA: comma_cnt++; when it reaches SYNC_COUNT, go to ACTIVE and set active=1 on the same edge.
  - At a boundary with cand!=COMMA: go to SEARCH, comma_cnt<=0.
  - Between boundaries, cand is ignored.
  - byte_strobe pulses at each boundary.
  - valid_out stays 0 and data_out is not updated.
- State ACTIVE:
  - At each boundary, byte_strobe=1 for that cycle.
  - If cand!=COMMA: data_out<=cand, valid_out<=1.
  - If cand==COMMA: valid_out<=0 and data_out holds its previous value.
  - Latency: the last bit of a byte sampled at edge k makes data_out/valid_out valid immediately after edge k.
  - Both outputs hold for 8 cycles until the next boundary.
  - ACTIVE is left only by reset. Misaligned commas are ignored, because data bytes may legally form COMMA across a boundary.
- active = (state==ACTIVE), registered.
- Boundary conditions:
  - A comma split across an idle-to-data transition is still only checked at aligned boundaries.
  - Back-to-back data bytes give continuous valid_out=1, with data_out changing every 8 cycles.
  - comma_cnt saturates; it has no effect after ACTIVE is reached.

Optional Feature:
- Macro SERIAL_PARALELO_RXCNT_EN.
- Defined:
  - Adds output rx_count[15:0]: count of data bytes accepted in ACTIVE (valid_out set at a boundary).
  - Saturates at 16'hFFFF; cleared to 0 by reset_L.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package/include holds:
  - COMMA value (8'hBC) and SYNC_COUNT default, shared with paralelo_serial.
  - State encoding: SEARCH=2'd0, SYNC=2'd1, ACTIVE=2'd2.
- Natural sub-module: serial_paralelo_aligner.
  - Contents: shift register, comma compare, bit_cnt.
  - Outputs: cand, boundary, and comma_hit to the top-level FSM/output register.

Test Plan:
- Reset, then 4×BC from bit 0:
  - active rises right after edge 32; byte_strobe pulses at edges 16, 24, 32; valid_out=0 throughout.
- After lock, send 8'h5A then 8'hC3:
  - data_out=5A, valid_out=1 after edge 40; data_out=C3 after edge 48.
  - Then send BC: valid_out=0 and data_out stays C3.
- Three junk bits (1,0,1), then 4×BC: lock is achieved with the boundary aligned to the comma; active after edge 35.
- BC, BC, 8'h00, then 4×BC: return to SEARCH after the 00 byte with active=0; relock after the next 4 commas.
- reset_L low for half a cycle mid-ACTIVE while valid_out=1: all outputs go 0 asynchronously; relock needs 4 new commas.
- With SERIAL_PARALELO_RXCNT_EN: lock, then 3 data bytes interleaved with commas → rx_count=3.
